// File: rtl/adder_tree_pkg.sv
// ----------------------------------------------------------------------------
// adder_tree_pkg
// Shared types and helpers for the serial signed adder tree.
//   state_t : control FSM states (ACC = collecting operands, DONE = result held)
//   sum_w   : exact result width for n operands of a given width
//   sext    : sign-extend the low 'from' bits of x to 'to' bits (upper bits zero)
// ----------------------------------------------------------------------------
package adder_tree_pkg;

    // Widest vector the sext helper can handle.
    localparam int MAX_W = 64;

    // Wide enough for an operand count up to 16.
    localparam int CNT_W = 5;

    typedef enum logic {
        ACC  = 1'b0,
        DONE = 1'b1
    } state_t;

    function automatic int sum_w(input int op_w, input int n);
        return op_w + $clog2(n);
    endfunction

    function automatic logic [MAX_W-1:0] sext(input logic [MAX_W-1:0] x,
                                              input int               from,
                                              input int               to);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < to) begin
                r[i] = (i < from) ? x[i] : x[from-1];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/adder_tree_acc_dp.sv
// ----------------------------------------------------------------------------
// adder_tree_acc_dp
// Accumulator datapath: running sum and operand count for one group.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   i_clr        drop the partial group (acc and count to zero)
//   i_add        accumulate i_data; wraps to empty on the last operand
//   i_load       start a new group with i_data as its first operand
//   i_data       signed operand, width bits
//   o_last       current operand would be the last of the group
//   o_sum_nxt    acc + sext(i_data), the group sum when o_last is set
// ----------------------------------------------------------------------------
module adder_tree_acc_dp
    import adder_tree_pkg::*;
#(
    parameter int unsigned width   = 20,
    parameter int unsigned NUM_OPS = 5,
    parameter int unsigned SUM_W   = 23
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_add,
    input  logic             i_load,
    input  logic [width-1:0] i_data,
    output logic             o_last,
    output logic [SUM_W-1:0] o_sum_nxt
);

    logic [SUM_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [SUM_W-1:0] w_data_ext;

    assign w_data_ext = SUM_W'(sext(MAX_W'(i_data), width, SUM_W));
    assign o_sum_nxt  = r_acc + w_data_ext;
    assign o_last     = (r_cnt == CNT_W'(NUM_OPS - 1));

    // Priority: clear, then accumulate, then load of a new group's first operand.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (i_add) begin
            if (o_last) begin
                // Result leaves through the top's output register.
                r_acc <= '0;
                r_cnt <= '0;
            end else begin
                r_acc <= o_sum_nxt;
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end else if (i_load) begin
            r_acc <= w_data_ext;
            r_cnt <= CNT_W'(1);
        end
    end

endmodule

// File: rtl/adder_tree_serial_acc.sv
// ----------------------------------------------------------------------------
// adder_tree_serial_acc
// Serial signed adder: sums NUM_OPS operands taken one per valid/ready beat
// and presents the exact sum on a registered valid/ready output.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   flush        abort the partial group (ignored while a result is pending)
//   in_valid     operand valid
//   in_ready     operand ready (combinational from state, flush and out_ready)
//   in_data      signed operand, width bits
//   out_valid    sum valid (registered)
//   out_ready    downstream accepts the sum
//   out_sum      signed group sum, SUM_W bits (registered)
//   out_cnt      groups delivered, wraps at 255 (registered)
// ----------------------------------------------------------------------------
module adder_tree_serial_acc
    import adder_tree_pkg::*;
#(
    parameter int unsigned width   = 20,
    parameter int unsigned NUM_OPS = 5,
    parameter int unsigned SUM_W   = sum_w(width, NUM_OPS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [width-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SUM_W-1:0] out_sum,
    output logic [7:0]       out_cnt
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_out_valid;
    logic [SUM_W-1:0] r_out_sum;
    logic [7:0]       r_out_cnt;

    logic             w_in_ready;
    logic             w_dp_clr;
    logic             w_dp_add;
    logic             w_dp_load;
    logic             w_complete;
    logic             w_take;
    logic             w_last;
    logic [SUM_W-1:0] w_sum_nxt;

    adder_tree_acc_dp #(
        .width   (width),
        .NUM_OPS (NUM_OPS),
        .SUM_W   (SUM_W)
    ) u_dp (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (w_dp_clr),
        .i_add     (w_dp_add),
        .i_load    (w_dp_load),
        .i_data    (in_data),
        .o_last    (w_last),
        .o_sum_nxt (w_sum_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ACC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_dp_clr    = 1'b0;
        w_dp_add    = 1'b0;
        w_dp_load   = 1'b0;
        w_complete  = 1'b0;
        unique case (r_state)
            ACC: begin
                if (flush) begin
                    // Operand presented alongside flush is dropped.
                    w_dp_clr = 1'b1;
                end else begin
                    w_in_ready = 1'b1;
                    if (in_valid) begin
                        w_dp_add = 1'b1;
                        if (w_last) begin
                            w_complete  = 1'b1;
                            w_state_nxt = DONE;
                        end
                    end
                end
            end
            DONE: begin
                // flush has no effect here; the pending result must be delivered.
                w_in_ready = out_ready;
                if (out_ready) begin
                    w_state_nxt = ACC;
                    // No bubble: the operand on the handshake cycle opens the next group.
                    w_dp_load   = in_valid;
                end
            end
        endcase
    end

    assign w_take = r_out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_cnt   <= '0;
        end else begin
            if (w_complete) begin
                r_out_valid <= 1'b1;
                r_out_sum   <= w_sum_nxt;
            end else if (w_take) begin
                r_out_valid <= 1'b0;
            end
            if (w_take) begin
                r_out_cnt <= r_out_cnt + 8'd1;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_cnt   = r_out_cnt;

endmodule
